// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, buffer-state encoding
// and the per-entry flag/metadata bundle carried alongside each result.
package ex_stage_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic       zero;
    logic       carry;
    logic       ovf;
    logic [4:0] rd;
    logic       wen;
    logic       exc;
  } ex_meta_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: AND, OR, ADD, SUB, SLT. Opcode bit 2 selects subtract in
// the shared adder, so carry always reflects that adder's carry-out.
module alu
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  carry,
  output logic                  ovf
);

  localparam int MSB = DATA_WIDTH - 1;

  logic                  sub;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH-1:0] sum;
  logic                  add_ovf;

  assign sub   = op[2];
  assign b_eff = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
  assign add_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_SUB: result = sum;
      ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, sum[MSB] ^ add_ovf};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign ovf  = is_arith(op) & add_ovf;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, one ALU, and a two-entry (main + skid)
// output buffer. Define EX_OVF_TRAP_EN to trap on ADD/SUB signed overflow.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_aluop,
  input  logic                  fwd_a,
  input  logic                  fwd_b,
  input  logic [4:0]            in_rd,
  input  logic                  in_wen,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_ovf,
  output logic [4:0]            out_rd,
  output logic                  out_wen,
  output logic                  out_exc
);

  buf_state_t            state;
  buf_state_t            state_nxt;
  logic [DATA_WIDTH-1:0] last_result;
  logic [DATA_WIDTH-1:0] main_result;
  logic [DATA_WIDTH-1:0] skid_result;
  ex_meta_t              main_meta;
  ex_meta_t              skid_meta;
  ex_meta_t              new_meta;

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_carry;
  logic                  alu_ovf;
  logic                  trap;
  logic                  accept;
  logic                  drain;

  assign op_a = fwd_a ? last_result : in_a;
  assign op_b = fwd_b ? last_result : in_b;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (in_aluop),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

`ifdef EX_OVF_TRAP_EN
  assign trap = alu_ovf;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    new_meta       = '0;
    new_meta.zero  = alu_zero;
    new_meta.carry = alu_carry;
    new_meta.ovf   = alu_ovf;
    new_meta.rd    = in_rd;
    new_meta.wen   = in_wen & ~trap;
    new_meta.exc   = trap;
  end

  // Ready comes from registered state only, never from out_ready.
  assign in_ready  = rst_n && (state != BUF_FULL);
  assign out_valid = (state != BUF_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (accept) state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (accept && !drain)      state_nxt = BUF_FULL;
        else if (!accept && drain) state_nxt = BUF_EMPTY;
      end
      BUF_FULL:  if (drain) state_nxt = BUF_ONE;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  end

  // NOTE: the skid entry is cleared on reset too, so no stale entry can resurface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_result <= '0;
      main_result <= '0;
      main_meta   <= '0;
      skid_result <= '0;
      skid_meta   <= '0;
    end else begin
      if (accept && !trap) last_result <= alu_result;
      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            main_result <= alu_result;
            main_meta   <= new_meta;
          end
        end
        BUF_ONE: begin
          if (accept && drain) begin
            main_result <= alu_result;
            main_meta   <= new_meta;
          end else if (accept) begin
            skid_result <= alu_result;
            skid_meta   <= new_meta;
          end else if (drain) begin
            main_result <= '0;
            main_meta   <= '0;
          end
        end
        BUF_FULL: begin
          if (drain) begin
            main_result <= skid_result;
            main_meta   <= skid_meta;
            skid_result <= '0;
            skid_meta   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = main_result;
  assign out_zero   = main_meta.zero;
  assign out_carry  = main_meta.carry;
  assign out_ovf    = main_meta.ovf;
  assign out_rd     = main_meta.rd;
  assign out_wen    = main_meta.wen;
  assign out_exc    = main_meta.exc;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a reference ALU/forwarding model pushes
// expected entries on acceptance; they are popped when the DUT drains.
module tb_ex_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_aluop;
  logic         fwd_a;
  logic         fwd_b;
  logic [4:0]   in_rd;
  logic         in_wen;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_carry;
  logic         out_ovf;
  logic [4:0]   out_rd;
  logic         out_wen;
  logic         out_exc;

  always #5 clk = ~clk;

  ex_stage #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_aluop   (in_aluop),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_exc    (out_exc)
  );

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic [4:0]   rd;
    logic         wen;
    logic         exc;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_mis = 0;
  logic [W-1:0] model_last = '0;

`ifdef EX_OVF_TRAP_EN
  localparam logic TRAP_ON = 1'b1;
`else
  localparam logic TRAP_ON = 1'b0;
`endif

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic [4:0] rd,
                                 input logic wen);
    exp_t       e;
    logic [W:0] s;
    logic [W-1:0] bb;
    logic       ov;
    e  = '0;
    bb = op[2] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op[2]};
    ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    case (op)
      3'b000:         e.result = a & b;
      3'b001:         e.result = a | b;
      3'b010, 3'b110: e.result = s[W-1:0];
      3'b111:         e.result[0] = ($signed(a) < $signed(b));
      default:        e.result = '0;
    endcase
    e.zero  = (e.result == '0);
    e.carry = s[W];
    e.ovf   = ((op == 3'b010) || (op == 3'b110)) && ov;
    e.rd    = rd;
    e.exc   = TRAP_ON & e.ovf;
    e.wen   = wen & ~e.exc;
    return e;
  endfunction

  // One clock: record acceptance into the scoreboard, compare any drained entry.
  task automatic tick();
    exp_t e;
    exp_t got;
    #1;
    if (in_valid && in_ready) begin
      e = model(fwd_a ? model_last : in_a, fwd_b ? model_last : in_b, in_aluop, in_rd, in_wen);
      sb.push_back(e);
      if (!e.exc) model_last = e.result;
    end
    if (out_valid && out_ready) begin
      got = {out_result, out_zero, out_carry, out_ovf, out_rd, out_wen, out_exc};
      n_vec++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL sb_unexpected got %h expected no output", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_mis++;
          $display("FAIL sb_entry got %h expected %h", got, e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic fa, input logic fb, input logic [4:0] rd, input logic wen);
    in_valid = 1'b1;
    in_aluop = op;
    in_a     = a;
    in_b     = b;
    fwd_a    = fa;
    fwd_b    = fb;
    in_rd    = rd;
    in_wen   = wen;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    fwd_a    = 1'b0;
    fwd_b    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; idle();
    in_a = '0; in_b = '0; in_aluop = '0; in_rd = '0; in_wen = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    n_vec++;
    if (in_ready !== 1'b0) begin n_mis++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    n_vec++;
    if ({out_result, out_zero, out_carry, out_ovf, out_rd, out_wen, out_exc} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs got result=%h rd=%h flags=%b%b%b%b%b expected all 0",
               out_result, out_rd, out_zero, out_carry, out_ovf, out_wen, out_exc);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin n_mis++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_add_ovf();
    out_ready = 1'b1;
    drive(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5'd3, 1'b1);
    tick();
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_ovf !== 1'b1 || out_carry !== 1'b0) begin
      n_mis++;
      $display("FAIL add_ovf got v=%b res=%h ovf=%b c=%b expected v=1 res=80000000 ovf=1 c=0",
               out_valid, out_result, out_ovf, out_carry);
    end
    n_vec++;
    if (out_exc !== TRAP_ON || out_wen !== ~TRAP_ON) begin
      n_mis++;
      $display("FAIL add_ovf_trap got exc=%b wen=%b expected exc=%b wen=%b", out_exc, out_wen, TRAP_ON, ~TRAP_ON);
    end
    tick();
  endtask

  task automatic test_sub_slt();
    out_ready = 1'b1;
    drive(3'b110, 32'd5, 32'd5, 1'b0, 1'b0, 5'd7, 1'b1);
    tick();
    n_vec++;
    if (out_result !== '0 || out_zero !== 1'b1 || out_carry !== 1'b1) begin
      n_mis++;
      $display("FAIL sub_eq got res=%h z=%b c=%b expected res=0 z=1 c=1", out_result, out_zero, out_carry);
    end
    drive(3'b111, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0, 5'd8, 1'b1);
    tick();
    idle();
    n_vec++;
    if (out_result !== 32'd1) begin
      n_mis++;
      $display("FAIL slt_fwd got %h expected 00000001", out_result);
    end
    tick();
  endtask

  task automatic test_reserved();
    logic [2:0] ops [3];
    ops = '{3'b100, 3'b011, 3'b101};
    out_ready = 1'b1;
    drive(ops[0], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd9, 1'b1);
    tick();
    n_vec++;
    if (out_result !== '0 || out_zero !== 1'b1 || out_ovf !== 1'b0 || out_exc !== 1'b0) begin
      n_mis++;
      $display("FAIL op100 got res=%h z=%b ovf=%b exc=%b expected res=0 z=1 ovf=0 exc=0",
               out_result, out_zero, out_ovf, out_exc);
    end
    for (int i = 1; i < 3; i++) begin
      drive(ops[i], $urandom(), $urandom(), 1'b0, 1'b0, 5'(i), 1'b1);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic acc;
    out_ready = 1'b0;
    drive(3'b010, 32'd1, 32'd2, 1'b0, 1'b0, 5'd1, 1'b1);
    tick();
    drive(3'b001, 32'hF0, 32'h0F, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();
    drive(3'b110, 32'd16, 32'd3, 1'b0, 1'b0, 5'd3, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0) begin n_mis++; $display("FAIL full_in_ready got %b expected 0", in_ready); end
    repeat (2) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_result !== 32'd3 || out_rd !== 5'd1) begin
        n_mis++;
        $display("FAIL stall_hold got v=%b res=%h rd=%0d expected v=1 res=00000003 rd=1",
                 out_valid, out_result, out_rd);
      end
    end
    out_ready = 1'b1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_mis++; $display("FAIL first_drain_in_ready got %b expected 0", in_ready); end
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    idle();
    n_vec++;
    if (acc !== 1'b1) begin n_mis++; $display("FAIL third_accept got %b expected 1 (timeout)", acc); end
    for (int i = 0; i < 6 && sb.size() > 0; i++) tick();
    n_vec++;
    if (sb.size() != 0) begin n_mis++; $display("FAIL b2b_drain got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'($urandom_range(7, 0)), $urandom(), $urandom(), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 1'b1);
      n_vec++;
      if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
        n_mis++;
        $display("FAIL stream_%0d got rdy=%b v=%b expected rdy=1 v=%b", i, in_ready, out_valid, i > 0);
      end
      tick();
    end
    idle();
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_mis++;
      $display("FAIL stream_end got v=%b pending=%0d expected v=0 pending=0", out_valid, sb.size());
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive(3'b010, 32'd100, 32'd23, 1'b0, 1'b0, 5'd4, 1'b1);
    tick();
    drive(3'b000, 32'hFF00, 32'h0FF0, 1'b0, 1'b0, 5'd5, 1'b1);
    tick();
    idle();
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL pre_reset_full got rdy=%b v=%b expected rdy=0 v=1", in_ready, out_valid);
    end
    rst_n = 1'b0;
    tick();
    sb.delete();
    model_last = '0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== '0 || out_rd !== '0) begin
      n_mis++;
      $display("FAIL reset_full got v=%b rdy=%b res=%h rd=%0d expected all 0", out_valid, in_ready, out_result, out_rd);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_mis++; $display("FAIL stale_after_reset got v=%b expected 0", out_valid); end
    drive(3'b010, $urandom(), $urandom(), 1'b1, 1'b1, 5'd6, 1'b1);
    tick();
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== '0) begin
      n_mis++;
      $display("FAIL last_result_cleared got v=%b res=%h expected v=1 res=0", out_valid, out_result);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_slt();
    test_reserved();
    test_back_to_back();
    test_stream();
    test_reset_full();
    n_vec++;
    if (sb.size() != 0) begin n_mis++; $display("FAIL final_pending got %0d expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-005 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have ports in_a and in_b  input  DATA_WIDTH each  raw operands.
REQ-007 SHALL have port in_aluop  input  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 SHALL have ports fwd_a and fwd_b  input  1 each  replace in_a/in_b with last_result.
REQ-009 SHALL have ports in_rd  input  5 and in_wen  input  1  destination register and write enable.
REQ-010 SHALL have ports out_valid  output  1 and out_ready  input  1  downstream handshake.
REQ-011 SHALL have port out_result  output  DATA_WIDTH  registered ALU result.
REQ-012 SHALL have ports out_zero, out_carry and out_ovf  output  1 each  registered ALU flags.
REQ-013 SHALL have ports out_rd  output  5, out_wen  output  1 and out_exc  output  1  forwarded destination, write enable and overflow exception.

Function
REQ-014 Transfers SHALL occur only when valid and ready are both high on a rising clk edge.
REQ-015 Effective operands: A = fwd_a ? last_result : in_a; B = fwd_b ? last_result : in_b.
REQ-016 The ALU SHALL evaluate combinationally on the effective operands; its result and flags SHALL be captured at acceptance.
- Latency: accept in cycle N gives out_valid in cycle N+1 when the stage was empty.
REQ-017 last_result SHALL update on every accepted operation except a trapped one (REQ-026).
- A forwarded operand in the cycle immediately after acceptance SHALL see the new value.
REQ-018 Buffering SHALL be two entries, main plus skid, with FIFO order and states EMPTY, ONE and FULL.
REQ-019 In_ready SHALL be high in EMPTY and ONE and low in FULL.
- in_ready SHALL NOT depend combinationally on out_ready.
REQ-020 State transitions:
- EMPTY + accept -> ONE.
- ONE + accept without drain -> FULL.
- ONE + drain without accept -> EMPTY.
- ONE + accept and drain together -> ONE, with the new entry in main.
- FULL + drain -> ONE, with skid moved to main.
REQ-021 While out_valid is high and out_ready is low, all out_* signals SHALL hold stable.
REQ-022 Opcodes 011, 100 and 101 SHALL give result 0, zero 1, ovf 0 and carry as produced by the adder; they SHALL pass through without error.
REQ-023 out_ovf SHALL be 0 for every opcode except ADD and SUB.
REQ-024 Out_* signals SHALL be don't-care when out_valid is low.
- The implementation SHALL still drive them to 0 when empty.

Reset
REQ-025 While rst_n is low at a clk edge, the following SHALL be cleared to 0:
- state (to EMPTY), out_valid, out_result, out_zero, out_carry, out_ovf, out_rd, out_wen, out_exc, last_result and the skid contents.
- in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
- Reset mid-transfer SHALL discard all buffered entries.

Configuration
REQ-026 Macro EX_OVF_TRAP_EN:
- When defined, an ADD or SUB with overflow SHALL set out_exc to 1 and force out_wen to 0 for that entry, and SHALL leave last_result unchanged.
- When undefined, out_exc SHALL be tied 0 and out_wen SHALL pass through unchanged.

Structure
REQ-027 A shared package SHALL hold the opcode constants (AND, OR, ADD, SUB, SLT) and the buffer-state encoding.
REQ-028 The existing alu module SHALL be instantiated once as the sole sub-module.
- Handshake and buffering SHALL be implemented in ex_stage itself.

Verification
REQ-029 ADD with A=0x7FFFFFFF, B=1 -> result 0x80000000, ovf 1, carry 0.
- With EX_OVF_TRAP_EN defined: out_exc 1 and out_wen 0.
REQ-030 SUB with A=5, B=5 -> result 0, zero 1, carry 1.
- A following SLT with fwd_a=1, B=1 -> result 1.
REQ-031 Hold out_ready=0 and offer 3 ops back-to-back -> first two accepted, in_ready 0 on the third.
- Then raise out_ready -> outputs drain in order, with the third accepted after the first drain.
REQ-032 Stream 8 ops with out_ready=1 and in_valid=1 each cycle -> one result per cycle in order, state remains ONE.
REQ-033 Assert rst_n=0 while in FULL -> next cycle out_valid 0, last_result 0, no stale output after release.
REQ-034 Opcode 100 with A=0xFFFFFFFF, B=0xFFFFFFFF -> result 0, zero 1, ovf 0.
